// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants, digit index type and helpers for the seven-segment scanner
package seg_scan_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF = 4'hF;
    typedef logic [1:0] digit_t;
    function automatic logic [3:0] an_onehot(digit_t idx);
        return ~(4'b0001 << idx);
    endfunction
    function automatic int cnt_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seg_scanner_if.sv
// seg_scanner_if: segment patterns in, multiplexed anode/cathode drive out
// Optional blink port present only when SEG_SCAN_BLINK_EN is defined.
interface seg_scanner_if;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [6:0] seg3;
`ifdef SEG_SCAN_BLINK_EN
    logic [3:0] blink;
`endif
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] digit_sel;
    modport master (
        output seg0, seg1, seg2, seg3,
`ifdef SEG_SCAN_BLINK_EN
        output blink,
`endif
        input an, seg, digit_sel
    );
    modport slave (
        input seg0, seg1, seg2, seg3,
`ifdef SEG_SCAN_BLINK_EN
        input blink,
`endif
        output an, seg, digit_sel
    );
endinterface

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: modulo-MOD counter with terminal-count pulse and post-blank drive flag
module scan_tick_gen import seg_scan_pkg::*; #(
    parameter int MOD = 8,
    parameter int BLANK = 2,
    localparam int W = cnt_w(MOD)
) (
    input logic clk,
    input logic rst,
    output logic [W-1:0] cnt,
    output logic tc,
    output logic drive
);
    assign tc = cnt == W'(MOD - 1);
    assign drive = cnt >= W'(BLANK);
    always_ff @(posedge clk)
        cnt <= rst || tc ? '0 : cnt + W'(1);
endmodule

// File: rtl/seg_scanner.sv
// seg_scanner: 4-digit time-multiplexed seven-segment driver with per-slot blanking guard
// Define SEG_SCAN_BLINK_EN to add per-digit blinking.
module seg_scanner import seg_scan_pkg::*; #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYCLES = 1000
`ifdef SEG_SCAN_BLINK_EN
    , parameter int BLINK_FRAMES = 125
`endif
) (
    input logic clk,
    input logic rst,
    seg_scanner_if.slave bus
);
    localparam int CW = cnt_w(REFRESH_DIV);
    localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES - 1);
    logic [CW-1:0] cnt;
    logic tc, drive, n_drive, hide, show, capture;
    digit_t idx, n_idx;
    logic [6:0] snap, n_snap, cur;
    scan_tick_gen #(.MOD(REFRESH_DIV), .BLANK(BLANK_CYCLES)) u_slot (
        .clk(clk), .rst(rst), .cnt(cnt), .tc(tc), .drive(drive)
    );
    // Outputs are registered from next-state so an/seg line up with cnt/idx without lag
    always_comb begin
        cur = idx == 2'd0 ? bus.seg0 : idx == 2'd1 ? bus.seg1 : idx == 2'd2 ? bus.seg2 : bus.seg3;
        capture = !drive && cnt == LAST_BLANK;
        n_idx = tc ? idx + 2'd1 : idx;
        n_drive = drive ? !tc : capture;
        n_snap = capture ? cur : snap;
        show = n_drive && !hide;
    end
`ifdef SEG_SCAN_BLINK_EN
    localparam int FW = cnt_w(BLINK_FRAMES);
    logic [FW-1:0] fcnt;
    logic bph, ftc, fwrap, n_bph;
    assign fwrap = tc && idx == 2'd3;
    assign ftc = fwrap && fcnt == FW'(BLINK_FRAMES - 1);
    assign n_bph = bph ^ ftc;
    assign hide = n_bph && bus.blink[n_idx];
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt <= '0;
            bph <= 1'b0;
        end else begin
            if (fwrap) fcnt <= ftc ? '0 : fcnt + FW'(1);
            bph <= n_bph;
        end
    end
`else
    assign hide = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            snap <= SEG_BLANK;
            bus.an <= AN_OFF;
            bus.seg <= SEG_BLANK;
            bus.digit_sel <= '0;
        end else begin
            idx <= n_idx;
            snap <= n_snap;
            bus.an <= show ? an_onehot(n_idx) : AN_OFF;
            bus.seg <= show ? n_snap : SEG_BLANK;
            bus.digit_sel <= n_idx;
        end
    end
endmodule

// File: tb/tb_seg_scanner.sv
// tb_seg_scanner: directed scan/reset/blink vectors with a cycle-tagged expectation queue
module tb_seg_scanner;
    import seg_scan_pkg::*;
    localparam int LIMIT = 5000;
    typedef struct {
        int cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] sel;
        string name;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int base = 0;
    int run = 2;
    logic live = 1'b0;
    logic [3:0] prev_an = 4'hF;
    exp_t q[$];
    exp_t e;
    logic [3:0] an_t [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_t [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_scanner_if bus();
    seg_scanner #(
        .REFRESH_DIV(8), .BLANK_CYCLES(2)
`ifdef SEG_SCAN_BLINK_EN
        , .BLINK_FRAMES(2)
`endif
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic push(input int c, input logic [3:0] an, input logic [6:0] sg, input logic [1:0] sel, input string name);
        exp_t x;
        x.cyc = c;
        x.an = an;
        x.seg = sg;
        x.sel = sel;
        x.name = name;
        q.push_back(x);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t && cyc < LIMIT) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_tests++;
            if (e.cyc != cyc || bus.an !== e.an || bus.seg !== e.seg || bus.digit_sel !== e.sel) begin
                n_fail++;
                $display("FAIL %s @cyc %0d (due %0d): got an=%h seg=%h sel=%0d, want an=%h seg=%h sel=%0d",
                         e.name, cyc, e.cyc, bus.an, bus.seg, bus.digit_sel, e.an, e.seg, e.sel);
            end
        end
        if (live) begin
            n_tests++;
            if ($countones(~bus.an) > 1 ||
                (bus.an != 4'hF && ((prev_an != 4'hF && prev_an != bus.an) || (prev_an == 4'hF && run < 2)))) begin
                n_fail++;
                $display("FAIL anode_guard @cyc %0d: an=%h prev=%h blank_run=%0d, want one-hot-low with >=2 blank cycles between digits",
                         cyc, bus.an, prev_an, run);
            end
            run = bus.an == 4'hF ? run + 1 : 0;
            prev_an = bus.an;
        end
        if (cyc == LIMIT && q.size() > 0) begin
            n_fail++;
            $display("FAIL timeout @cyc %0d: %0d expectations pending, want 0", cyc, q.size());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        bus.seg0 = 7'h40;
        bus.seg1 = 7'h79;
        bus.seg2 = 7'h24;
        bus.seg3 = 7'h30;
`ifdef SEG_SCAN_BLINK_EN
        bus.blink = 4'b0000;
`endif
        repeat (3) @(negedge clk);
        // Two full frames after reset release; seg0 changes mid slot 0 of frame 0
        base = cyc + 1;
        for (int k = 0; k < 64; k++) begin
            automatic int d = (k / 8) % 4;
            automatic int c = k % 8;
            automatic logic [6:0] s = d == 0 ? (k < 32 ? 7'h40 : 7'h79) : seg_t[d];
            push(base + k, c < 2 ? 4'hF : an_t[d], c < 2 ? 7'h7F : s, 2'(d), k < 32 ? "frame0" : "frame1");
        end
        @(negedge clk);
        rst = 1'b0;
        live = 1'b1;
        wait_until(base + 4);
        bus.seg0 = 7'h79;
        wait_until(base + 84);
        push(base + 85, 4'hB, 7'h24, 2'd2, "pre_rst");
        @(negedge clk);
        rst = 1'b1;
        base = cyc + 1;
        push(base, 4'hF, 7'h7F, 2'd0, "rst_c0");
        push(base + 1, 4'hF, 7'h7F, 2'd0, "rst_c1");
        push(base + 2, 4'hE, 7'h79, 2'd0, "rst_relight");
        push(base + 7, 4'hE, 7'h79, 2'd0, "rst_slot_end");
        push(base + 8, 4'hF, 7'h7F, 2'd1, "rst_next_slot");
        @(negedge clk);
        rst = 1'b0;
        wait_until(base + 9);
        for (int i = 0; i < 1000; i++) begin
            bus.seg0 = 7'($urandom);
            bus.seg1 = 7'($urandom);
            bus.seg2 = 7'($urandom);
            bus.seg3 = 7'($urandom);
            @(negedge clk);
        end
        bus.seg0 = 7'h40;
        bus.seg1 = 7'h79;
        bus.seg2 = 7'h24;
        bus.seg3 = 7'h30;
`ifdef SEG_SCAN_BLINK_EN
        rst = 1'b1;
        bus.blink = 4'b0010;
        base = cyc + 1;
        for (int f = 0; f < 6; f++) begin
            automatic logic hid = f == 2 || f == 3;
            push(base + f * 32 + 5, 4'hE, 7'h40, 2'd0, "blink_d0");
            push(base + f * 32 + 10, hid ? 4'hF : 4'hD, hid ? 7'h7F : 7'h79, 2'd1, "blink_d1a");
            push(base + f * 32 + 15, hid ? 4'hF : 4'hD, hid ? 7'h7F : 7'h79, 2'd1, "blink_d1b");
            push(base + f * 32 + 20, 4'hB, 7'h24, 2'd2, "blink_d2");
            push(base + f * 32 + 29, 4'h7, 7'h30, 2'd3, "blink_d3");
        end
        @(negedge clk);
        rst = 1'b0;
`endif
        while (q.size() > 0 && cyc < LIMIT + 2) @(negedge clk);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
